// File: rtl/cpu_axi_bridge_pkg.sv
// cpu_axi_bridge_pkg: shared definitions for the core-to-AXI4 bridge.
//   - FSM state encoding (3-bit)
//   - AXI size / response encodings, single-beat INCR burst constants
//   - default ARID/AWID values for fetch and data traffic
package cpu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD_AR  = 3'd1,
    ST_RD_R   = 3'd2,
    ST_WR_AWW = 3'd3,
    ST_WR_B   = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam logic [2:0] AXI_SIZE_B = 3'd0;
  localparam logic [2:0] AXI_SIZE_H = 3'd1;
  localparam logic [2:0] AXI_SIZE_W = 3'd2;
  localparam logic [2:0] AXI_SIZE_D = 3'd3;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int IF_ID_DEF  = 0;
  localparam int MEM_ID_DEF = 1;

  // Core size code (bytes = 1<<size) to AXI AxSIZE.
  function automatic logic [2:0] axi_size(input logic [1:0] size);
    return {1'b0, size};
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_lane_align.sv
// axi_lane_align: combinational byte-lane steering between the core's
// right-justified data and the 64-bit AXI bus lanes.
//   size     : access size code (bytes = 1<<size)
//   offset   : addr[2:0] of the access
//   wdata_in : right-justified core write data
//   rdata_in : raw AXI read data
//   wdata    : write data moved up to its byte lane
//   wstrb    : byte strobes; lanes past byte 7 fall off (misaligned truncation)
//   rdata    : read data moved down to bit 0 and zero-masked to size
module axi_lane_align #(
  parameter int DATA_W = 64
) (
  input  logic [1:0]          size,
  input  logic [2:0]          offset,
  input  logic [DATA_W-1:0]   wdata_in,
  input  logic [DATA_W-1:0]   rdata_in,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata
);
  localparam int STRB_W = DATA_W / 8;

  logic [DATA_W-1:0] size_mask;
  logic [STRB_W-1:0] strb_base;

  always_comb begin
    size_mask = '0;
    strb_base = '0;
    for (int i = 0; i < STRB_W; i++) begin
      if (i < (1 << size)) begin
        size_mask[i*8 +: 8] = 8'hFF;
        strb_base[i]        = 1'b1;
      end
    end
  end

  assign wdata = wdata_in << {offset, 3'b000};
  assign wstrb = strb_base << offset;
  assign rdata = (rdata_in >> {offset, 3'b000}) & size_mask;

endmodule

// File: rtl/cpu_axi_bridge.sv
// cpu_axi_bridge: serialises the core's fetch (if_*) and data (mem_*) ports
// onto one AXI4 master, one single-beat transaction in flight at a time.
// Data access wins over fetch when both request in the same cycle.
//   clock/reset    : synchronous active-high reset
//   if_*           : fetch request/completion (read only)
//   mem_*          : data load/store request/completion
//   axi_aw/w/b/ar/r: AXI4 master channels (LEN=0, BURST=INCR)
// Optional: define CPU_AXI_BRIDGE_PERF_EN to add perf_rd_cnt, perf_wr_cnt
// and perf_stall_cnt outputs.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter int IF_ID  = IF_ID_DEF,
  parameter int MEM_ID = MEM_ID_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                if_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic [1:0]          if_size,
  input  logic                if_req,
  output logic                if_ready,
  output logic [DATA_W-1:0]   if_data_read,
  output logic [1:0]          if_resp,
  input  logic                mem_valid,
  input  logic                mem_req,
  input  logic [ADDR_W-1:0]   mem_addr,
  input  logic [1:0]          mem_size,
  input  logic [DATA_W-1:0]   mem_data_write,
  output logic                mem_ready,
  output logic [DATA_W-1:0]   mem_data_read,
  output logic [1:0]          mem_resp,
  output logic                axi_aw_valid,
  input  logic                axi_aw_ready,
  output logic [ADDR_W-1:0]   axi_aw_addr,
  output logic [2:0]          axi_aw_size,
  output logic [ID_W-1:0]     axi_aw_id,
  output logic [7:0]          axi_aw_len,
  output logic [1:0]          axi_aw_burst,
  output logic                axi_w_valid,
  input  logic                axi_w_ready,
  output logic [DATA_W-1:0]   axi_w_data,
  output logic [DATA_W/8-1:0] axi_w_strb,
  output logic                axi_w_last,
  input  logic                axi_b_valid,
  output logic                axi_b_ready,
  input  logic [1:0]          axi_b_resp,
  input  logic [ID_W-1:0]     axi_b_id,
  output logic                axi_ar_valid,
  input  logic                axi_ar_ready,
  output logic [ADDR_W-1:0]   axi_ar_addr,
  output logic [2:0]          axi_ar_size,
  output logic [ID_W-1:0]     axi_ar_id,
  output logic [7:0]          axi_ar_len,
  output logic [1:0]          axi_ar_burst,
  input  logic                axi_r_valid,
  output logic                axi_r_ready,
  input  logic [DATA_W-1:0]   axi_r_data,
  input  logic [1:0]          axi_r_resp,
  input  logic                axi_r_last,
  input  logic [ID_W-1:0]     axi_r_id
`ifdef CPU_AXI_BRIDGE_PERF_EN
  ,output logic [63:0]        perf_rd_cnt,
  output logic [63:0]         perf_wr_cnt,
  output logic [63:0]         perf_stall_cnt
`endif
);
  localparam int STRB_W = DATA_W / 8;

  state_e              state, state_nxt;
  logic                is_mem_q, is_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          size_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [ID_W-1:0]     id_q;
  logic [1:0]          resp_q;
  logic                aw_done_q, w_done_q;
  logic [DATA_W-1:0]   lane_wdata, lane_rdata;
  logic [STRB_W-1:0]   lane_strb;
  logic                done;

  // Single outstanding transaction: response IDs and RLAST carry no
  // information, and fetches are always reads.
  logic unused_inputs;
  assign unused_inputs = ^{if_req, axi_r_last, axi_r_id, axi_b_id};

  axi_lane_align #(.DATA_W(DATA_W)) u_align (
    .size    (size_q),
    .offset  (addr_q[2:0]),
    .wdata_in(wdata_q),
    .rdata_in(axi_r_data),
    .wdata   (lane_wdata),
    .wstrb   (lane_strb),
    .rdata   (lane_rdata)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (mem_valid)     state_nxt = mem_req ? ST_WR_AWW : ST_RD_AR;
        else if (if_valid) state_nxt = ST_RD_AR;
      end
      ST_RD_AR: begin
        axi_ar_valid = 1'b1;
        if (axi_ar_ready) state_nxt = ST_RD_R;
      end
      ST_RD_R: begin
        axi_r_ready = 1'b1;
        if (axi_r_valid) state_nxt = ST_RESP;
      end
      ST_WR_AWW: begin
        // Each valid stays up only until its own handshake; a channel is
        // finished if it handshook earlier or is handshaking right now.
        axi_aw_valid = ~aw_done_q;
        axi_w_valid  = ~w_done_q;
        if ((aw_done_q | axi_aw_ready) && (w_done_q | axi_w_ready))
          state_nxt = ST_WR_B;
      end
      ST_WR_B: begin
        axi_b_ready = 1'b1;
        if (axi_b_valid) state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      is_mem_q  <= 1'b0;
      is_wr_q   <= 1'b0;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      id_q      <= '0;
      resp_q    <= AXI_RESP_OKAY;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          if (mem_valid) begin
            is_mem_q <= 1'b1;
            is_wr_q  <= mem_req;
            addr_q   <= mem_addr;
            size_q   <= mem_size;
            wdata_q  <= mem_data_write;
            id_q     <= ID_W'(MEM_ID);
          end else if (if_valid) begin
            is_mem_q <= 1'b0;
            is_wr_q  <= 1'b0;
            addr_q   <= if_addr;
            size_q   <= if_size;
            id_q     <= ID_W'(IF_ID);
          end
        end
        ST_WR_AWW: begin
          if (axi_aw_valid && axi_aw_ready) aw_done_q <= 1'b1;
          if (axi_w_valid && axi_w_ready)   w_done_q  <= 1'b1;
        end
        ST_RD_R: begin
          if (axi_r_valid) begin
            rdata_q <= lane_rdata;
            resp_q  <= axi_r_resp;
          end
        end
        ST_WR_B: begin
          if (axi_b_valid) begin
            rdata_q <= '0;
            resp_q  <= axi_b_resp;
          end
        end
        default: ;
      endcase
    end
  end

  // Completion is the RESP state itself; data/resp are shown only on the
  // port that owns the transaction and only during its ready cycle.
  assign done          = (state == ST_RESP);
  assign if_ready      = done & ~is_mem_q;
  assign mem_ready     = done & is_mem_q;
  assign if_data_read  = if_ready  ? rdata_q : '0;
  assign mem_data_read = mem_ready ? rdata_q : '0;
  assign if_resp       = if_ready  ? resp_q  : 2'b00;
  assign mem_resp      = mem_ready ? resp_q  : 2'b00;

  assign axi_aw_addr  = addr_q;
  assign axi_ar_addr  = addr_q;
  assign axi_aw_size  = axi_size(size_q);
  assign axi_ar_size  = axi_size(size_q);
  assign axi_aw_id    = id_q;
  assign axi_ar_id    = id_q;
  assign axi_aw_len   = AXI_LEN_SINGLE;
  assign axi_ar_len   = AXI_LEN_SINGLE;
  assign axi_aw_burst = AXI_BURST_INCR;
  assign axi_ar_burst = AXI_BURST_INCR;
  assign axi_w_data   = lane_wdata;
  assign axi_w_strb   = lane_strb;
  assign axi_w_last   = 1'b1;

`ifdef CPU_AXI_BRIDGE_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (done && !is_wr_q)   perf_rd_cnt    <= perf_rd_cnt + 64'd1;
      if (done && is_wr_q)    perf_wr_cnt    <= perf_wr_cnt + 64'd1;
      if (state != ST_IDLE)   perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cpu_axi_bridge.sv
module tb_cpu_axi_bridge;
  import cpu_axi_bridge_pkg::*;

  logic clock, reset;
  logic if_valid, if_req, if_ready;
  logic [63:0] if_addr, if_data_read;
  logic [1:0] if_size, if_resp;
  logic mem_valid, mem_req, mem_ready;
  logic [63:0] mem_addr, mem_data_write, mem_data_read;
  logic [1:0] mem_size, mem_resp;
  logic axi_aw_valid, axi_aw_ready, axi_w_valid, axi_w_ready, axi_w_last;
  logic [63:0] axi_aw_addr, axi_ar_addr, axi_w_data, axi_r_data;
  logic [2:0] axi_aw_size, axi_ar_size;
  logic [3:0] axi_aw_id, axi_ar_id, axi_b_id, axi_r_id;
  logic [7:0] axi_aw_len, axi_ar_len, axi_w_strb;
  logic [1:0] axi_aw_burst, axi_ar_burst, axi_b_resp, axi_r_resp;
  logic axi_b_valid, axi_b_ready, axi_ar_valid, axi_ar_ready;
  logic axi_r_valid, axi_r_ready, axi_r_last;
`ifdef CPU_AXI_BRIDGE_PERF_EN
  logic [63:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  cpu_axi_bridge #(.ADDR_W(64), .DATA_W(64), .ID_W(4), .IF_ID(0), .MEM_ID(1)) dut (
    .clock(clock), .reset(reset),
    .if_valid(if_valid), .if_addr(if_addr), .if_size(if_size), .if_req(if_req),
    .if_ready(if_ready), .if_data_read(if_data_read), .if_resp(if_resp),
    .mem_valid(mem_valid), .mem_req(mem_req), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_data_write(mem_data_write), .mem_ready(mem_ready), .mem_data_read(mem_data_read),
    .mem_resp(mem_resp),
    .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_addr(axi_aw_addr),
    .axi_aw_size(axi_aw_size), .axi_aw_id(axi_aw_id), .axi_aw_len(axi_aw_len),
    .axi_aw_burst(axi_aw_burst),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_resp(axi_b_resp),
    .axi_b_id(axi_b_id),
    .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_addr(axi_ar_addr),
    .axi_ar_size(axi_ar_size), .axi_ar_id(axi_ar_id), .axi_ar_len(axi_ar_len),
    .axi_ar_burst(axi_ar_burst),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_data(axi_r_data),
    .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last), .axi_r_id(axi_r_id)
`ifdef CPU_AXI_BRIDGE_PERF_EN
    ,.perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- slave model (acts on negedge) ----------------
  int ar_delay = 0, aw_delay = 0, w_delay = 0;
  logic [1:0] rd_resp = 2'b00, wr_resp = 2'b00;
  bit force_en = 0, r_hold = 0;
  logic [63:0] force_word = '0;
  logic [63:0] last_rword, last_araddr, last_waddr, last_wdata;
  logic [2:0]  last_arsize, last_awsize;
  logic [3:0]  last_awid;
  logic [7:0]  last_wstrb;
  logic        last_wlast;
  logic [3:0]  ar_ids[$];
  int proto_err = 0, if_pulses = 0, mem_pulses = 0;

  initial begin
    bit p_ar_v, p_ar_r, p_r_v, p_r_r, p_aw_v, p_aw_r, p_w_v, p_w_r, p_b_v, p_b_r;
    bit r_due, aw_got, w_got;
    int ar_wait, aw_wait, w_wait;
    axi_ar_ready = 0; axi_aw_ready = 0; axi_w_ready = 0;
    axi_r_valid = 0; axi_r_data = '0; axi_r_resp = 0; axi_r_last = 0; axi_r_id = 0;
    axi_b_valid = 0; axi_b_resp = 0; axi_b_id = 0;
    forever begin
      @(negedge clock);
      if (reset) begin
        axi_ar_ready = 0; axi_aw_ready = 0; axi_w_ready = 0;
        axi_r_valid = 0; axi_b_valid = 0;
        {p_ar_v, p_ar_r, p_r_v, p_r_r, p_aw_v, p_aw_r, p_w_v, p_w_r, p_b_v, p_b_r} = '0;
        r_due = 0; aw_got = 0; w_got = 0; ar_wait = 0; aw_wait = 0; w_wait = 0;
        continue;
      end
      // handshakes completed at the posedge just passed
      if (p_ar_v && p_ar_r) begin
        ar_ids.push_back(axi_ar_id);
        last_araddr = axi_ar_addr; last_arsize = axi_ar_size; r_due = 1;
      end
      if (p_r_v && p_r_r) axi_r_valid = 0;
      if (p_aw_v && p_aw_r) begin
        aw_got = 1; last_waddr = axi_aw_addr; last_awsize = axi_aw_size; last_awid = axi_aw_id;
      end
      if (p_w_v && p_w_r) begin
        w_got = 1; last_wdata = axi_w_data; last_wstrb = axi_w_strb; last_wlast = axi_w_last;
      end
      if (p_b_v && p_b_r) begin
        axi_b_valid = 0; aw_got = 0; w_got = 0;
      end
      // protocol monitors
      if (aw_got && axi_aw_valid) proto_err++;
      if (w_got && axi_w_valid) proto_err++;
      if (axi_b_ready && !(aw_got && w_got)) proto_err++;
      if (axi_ar_valid && (axi_aw_valid || axi_w_valid)) proto_err++;
      // responses
      if (r_due && !r_hold) begin
        axi_r_data = force_en ? force_word : {$urandom, $urandom};
        last_rword = axi_r_data;
        axi_r_valid = 1; axi_r_resp = rd_resp; axi_r_last = 1; axi_r_id = 4'($urandom);
        r_due = 0;
      end
      if (aw_got && w_got && !axi_b_valid) begin
        axi_b_valid = 1; axi_b_resp = wr_resp; axi_b_id = 4'($urandom);
      end
      // address/data readies after a programmable number of valid cycles
      if (axi_ar_valid) begin axi_ar_ready = (ar_wait >= ar_delay); ar_wait++; end
      else begin axi_ar_ready = 0; ar_wait = 0; end
      if (axi_aw_valid) begin axi_aw_ready = (aw_wait >= aw_delay); aw_wait++; end
      else begin axi_aw_ready = 0; aw_wait = 0; end
      if (axi_w_valid) begin axi_w_ready = (w_wait >= w_delay); w_wait++; end
      else begin axi_w_ready = 0; w_wait = 0; end
      if (if_ready) if_pulses++;
      if (mem_ready) mem_pulses++;
      p_ar_v = axi_ar_valid; p_ar_r = axi_ar_ready; p_r_v = axi_r_valid; p_r_r = axi_r_ready;
      p_aw_v = axi_aw_valid; p_aw_r = axi_aw_ready; p_w_v = axi_w_valid; p_w_r = axi_w_ready;
      p_b_v = axi_b_valid; p_b_r = axi_b_ready;
    end
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] exp_read(input logic [63:0] word, input int off, input int sz);
    logic [63:0] e = '0;
    for (int k = 0; k < (1 << sz); k++)
      if (off + k < 8) e[8*k +: 8] = word[8*(off+k) +: 8];
    return e;
  endfunction

  function automatic logic [63:0] exp_wdata(input logic [63:0] d, input int off);
    logic [63:0] e = '0;
    for (int k = 0; k + off < 8; k++) e[8*(off+k) +: 8] = d[8*k +: 8];
    return e;
  endfunction

  function automatic logic [7:0] exp_strb(input int off, input int sz);
    logic [7:0] s = '0;
    for (int k = 0; k < (1 << sz); k++)
      if (off + k < 8) s[off+k] = 1'b1;
    return s;
  endfunction

  function automatic logic [1:0] pick_resp(input int n);
    case (n)
      0: return AXI_RESP_OKAY;
      1: return AXI_RESP_EXOKAY;
      2: return AXI_RESP_SLVERR;
      default: return AXI_RESP_DECERR;
    endcase
  endfunction

  function automatic logic [1:0] pick_size(input int n);
    case (n)
      0: return AXI_SIZE_B[1:0];
      1: return AXI_SIZE_H[1:0];
      2: return AXI_SIZE_W[1:0];
      default: return AXI_SIZE_D[1:0];
    endcase
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Issue one request, wait (bounded) for its ready, then check the pulse ends.
  task automatic run_txn(input bit m, input bit wr, input logic [63:0] addr, input logic [1:0] sz,
                         input logic [63:0] wd, output logic [63:0] rd, output logic [1:0] rs,
                         output int lat);
    bit got = 0;
    rd = '0; rs = '0; lat = 0;
    if (m) begin
      mem_valid = 1; mem_req = wr; mem_addr = addr; mem_size = sz; mem_data_write = wd;
    end else begin
      if_valid = 1; if_req = 0; if_addr = addr; if_size = sz;
    end
    while (!got && lat < 100) begin
      tick(); lat++;
      if (m ? mem_ready : if_ready) begin
        got = 1;
        rd = m ? mem_data_read : if_data_read;
        rs = m ? mem_resp : if_resp;
      end
    end
    mem_valid = 0; if_valid = 0;
    checks++;
    if (!got) begin errors++; $display("FAIL txn_timeout: no ready after %0d cycles, required one", lat); end
    tick();
    checks++;
    if ({if_ready, mem_ready} !== 2'b00) begin
      errors++; $display("FAIL ready_one_cycle: ready=%b after pulse, required 00", {if_ready, mem_ready});
    end
  endtask

  task automatic test_reset();
    reset = 1; if_valid = 0; mem_valid = 0; if_req = 0; mem_req = 0;
    if_addr = '0; if_size = '0; mem_addr = '0; mem_size = '0; mem_data_write = '0;
    repeat (3) tick();
    reset = 0;
    tick();
    checks++;
    if ({axi_ar_valid, axi_aw_valid, axi_w_valid, axi_r_ready, axi_b_ready, if_ready, mem_ready} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b required 0",
        {axi_ar_valid, axi_aw_valid, axi_w_valid, axi_r_ready, axi_b_ready, if_ready, mem_ready});
    end
    checks++;
    if ({if_data_read, mem_data_read, if_resp, mem_resp} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %b %b required 0", if_data_read, mem_data_read, if_resp, mem_resp);
    end
    checks++;
    if ({axi_aw_len, axi_ar_len, axi_aw_burst, axi_ar_burst, axi_w_last} !== {16'h0, 2'b01, 2'b01, 1'b1}) begin
      errors++; $display("FAIL burst_consts: len %h/%h burst %b/%b last %b required 0/0 01/01 1",
        axi_aw_len, axi_ar_len, axi_aw_burst, axi_ar_burst, axi_w_last);
    end
`ifdef CPU_AXI_BRIDGE_PERF_EN
    checks++;
    if ({perf_rd_cnt, perf_wr_cnt, perf_stall_cnt} !== '0) begin
      errors++; $display("FAIL perf_reset: %0d %0d %0d required 0", perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_fetch();
    logic [63:0] rd; logic [1:0] rs; int lat, mp;
    force_en = 1; force_word = 64'h1234_5678_0000_0000; rd_resp = AXI_RESP_OKAY; ar_delay = 0;
    ar_ids.delete(); mp = mem_pulses;
    run_txn(0, 0, 64'h8000_0004, 2'd2, '0, rd, rs, lat);
    force_en = 0;
    checks++;
    if (rd !== 64'h1234_5678) begin errors++; $display("FAIL fetch_data: got %h required 12345678", rd); end
    checks++;
    if (rs !== 2'b00) begin errors++; $display("FAIL fetch_resp: got %b required 00", rs); end
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL fetch_latency: got %0d required 3", lat); end
    checks++;
    if (ar_ids.size() != 1 || ar_ids[0] !== 4'd0 || last_araddr !== 64'h8000_0004 || last_arsize !== 3'd2) begin
      errors++; $display("FAIL fetch_ar: ids=%0d addr=%h size=%0d required 1 id0 80000004 2",
        ar_ids.size(), last_araddr, last_arsize);
    end
    checks++;
    if (mem_pulses !== mp) begin errors++; $display("FAIL fetch_mem_quiet: mem pulses %0d required %0d", mem_pulses, mp); end
`ifdef CPU_AXI_BRIDGE_PERF_EN
    checks++;
    if ({perf_rd_cnt, perf_wr_cnt, perf_stall_cnt} !== {64'd1, 64'd0, 64'd3}) begin
      errors++; $display("FAIL perf_fetch: %0d %0d %0d required 1 0 3", perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
`endif
  endtask

  task automatic test_byte_store();
    logic [63:0] rd; logic [1:0] rs; int lat;
    aw_delay = 0; w_delay = 0; wr_resp = AXI_RESP_OKAY;
    run_txn(1, 1, 64'h8000_1003, 2'd0, 64'hAB, rd, rs, lat);
    checks++;
    if (last_wdata[31:24] !== 8'hAB || last_wstrb !== 8'h08 || last_wlast !== 1'b1) begin
      errors++; $display("FAIL store_lane: byte3=%h strb=%h last=%b required AB 08 1",
        last_wdata[31:24], last_wstrb, last_wlast);
    end
    checks++;
    if (last_awid !== 4'd1 || last_waddr !== 64'h8000_1003 || last_awsize !== 3'd0) begin
      errors++; $display("FAIL store_aw: id=%0d addr=%h size=%0d required 1 80001003 0", last_awid, last_waddr, last_awsize);
    end
    checks++;
    if (lat !== 3 || rs !== 2'b00) begin errors++; $display("FAIL store_done: lat=%0d resp=%b required 3 00", lat, rs); end
  endtask

  task automatic test_write_order();
    logic [63:0] rd, a, d; logic [1:0] rs, sz; int lat, pe;
    for (int c = 0; c < 3; c++) begin
      w_delay  = (c == 0) ? 0 : (c == 1) ? 4 : 2;
      aw_delay = (c == 0) ? 4 : (c == 1) ? 0 : 2;
      wr_resp = pick_resp($urandom_range(0, 3));
      a = {$urandom, $urandom}; d = {$urandom, $urandom}; sz = pick_size($urandom_range(0, 3));
      pe = proto_err;
      run_txn(1, 1, a, sz, d, rd, rs, lat);
      checks++;
      if (proto_err !== pe) begin errors++; $display("FAIL order%0d_protocol: %0d violations required 0", c, proto_err - pe); end
      checks++;
      if (lat !== 7 && c != 2) begin errors++; $display("FAIL order%0d_latency: got %0d required 7", c, lat); end
      else if (c == 2 && lat !== 5) begin errors++; $display("FAIL order2_latency: got %0d required 5", lat); end
      checks++;
      if (last_wdata !== exp_wdata(d, int'(a[2:0])) || last_wstrb !== exp_strb(int'(a[2:0]), int'(sz)) || rs !== wr_resp) begin
        errors++; $display("FAIL order%0d_data: wdata=%h strb=%h resp=%b required %h %h %b", c, last_wdata, last_wstrb, rs,
          exp_wdata(d, int'(a[2:0])), exp_strb(int'(a[2:0]), int'(sz)), wr_resp);
      end
    end
    aw_delay = 0; w_delay = 0;
  endtask

  task automatic test_arbitration();
    logic [63:0] mword, mdata, fdata; int n, ifp;
    bit mgot = 0, fgot = 0;
    ar_ids.delete(); rd_resp = AXI_RESP_OKAY; ar_delay = 1; ifp = if_pulses;
    mem_valid = 1; mem_req = 0; mem_addr = 64'h10; mem_size = 2'd3;
    if_valid = 1; if_req = 0; if_addr = 64'h2002; if_size = 2'd1;
    n = 0; mword = '0; mdata = '0; fdata = '0;
    while (!mgot && n < 50) begin
      tick(); n++;
      if (mem_ready) begin mgot = 1; mdata = mem_data_read; mword = last_rword; mem_valid = 0; end
    end
    checks++;
    if (!mgot || if_pulses !== ifp) begin
      errors++; $display("FAIL arb_mem_first: mem_done=%0d if_pulses=%0d required 1 0", mgot, if_pulses - ifp);
    end
    n = 0;
    while (!fgot && n < 50) begin
      tick(); n++;
      if (if_ready) begin fgot = 1; fdata = if_data_read; if_valid = 0; end
    end
    tick();
    checks++;
    if (!fgot || ar_ids.size() != 2 || ar_ids[0] !== 4'd1 || ar_ids[1] !== 4'd0) begin
      errors++; $display("FAIL arb_order: fetch_done=%0d ar count=%0d required 1 2 (ids 1 then 0)", fgot, ar_ids.size());
    end
    checks++;
    if (mdata !== exp_read(mword, 0, 3) || fdata !== exp_read(last_rword, 2, 1)) begin
      errors++; $display("FAIL arb_data: mem=%h fetch=%h required %h %h", mdata, fdata,
        exp_read(mword, 0, 3), exp_read(last_rword, 2, 1));
    end
    ar_delay = 0;
  endtask

  task automatic test_error();
    logic [63:0] rd; logic [1:0] rs; int lat;
    rd_resp = AXI_RESP_SLVERR;
    run_txn(1, 0, 64'h8000_0020, 2'd2, '0, rd, rs, lat);
    checks++;
    if (rs !== AXI_RESP_SLVERR) begin errors++; $display("FAIL err_resp: got %b required 10", rs); end
    rd_resp = AXI_RESP_OKAY;
    run_txn(1, 0, 64'h8000_0021, 2'd0, '0, rd, rs, lat);
    checks++;
    if (rs !== 2'b00 || lat !== 3) begin errors++; $display("FAIL err_recover: resp=%b lat=%0d required 00 3", rs, lat); end
  endtask

  task automatic test_random();
    logic [63:0] rd, a, d; logic [1:0] rs, sz, er; bit m, wr; int lat, el;
    for (int n = 0; n < 24; n++) begin
      m = 1'($urandom_range(0, 1)); wr = m ? 1'($urandom_range(0, 1)) : 1'b0;
      a = {$urandom, $urandom}; d = {$urandom, $urandom}; sz = pick_size($urandom_range(0, 3));
      ar_delay = $urandom_range(0, 3); aw_delay = $urandom_range(0, 3); w_delay = $urandom_range(0, 3);
      rd_resp = pick_resp($urandom_range(0, 3)); wr_resp = pick_resp($urandom_range(0, 3));
      ar_ids.delete();
      run_txn(m, wr, a, sz, d, rd, rs, lat);
      er = wr ? wr_resp : rd_resp;
      el = wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) : 3 + ar_delay;
      checks++;
      if (rs !== er || lat !== el) begin
        errors++; $display("FAIL rand%0d_resp_lat: resp=%b lat=%0d required %b %0d", n, rs, lat, er, el);
      end
      checks++;
      if (wr) begin
        if (last_wdata !== exp_wdata(d, int'(a[2:0])) || last_wstrb !== exp_strb(int'(a[2:0]), int'(sz)) ||
            last_awid !== 4'd1 || last_waddr !== a) begin
          errors++; $display("FAIL rand%0d_write: wdata=%h strb=%h id=%0d required %h %h 1", n, last_wdata, last_wstrb,
            last_awid, exp_wdata(d, int'(a[2:0])), exp_strb(int'(a[2:0]), int'(sz)));
        end
      end else begin
        if (rd !== exp_read(last_rword, int'(a[2:0]), int'(sz)) || ar_ids.size() != 1 || ar_ids[0] !== {3'b0, m}) begin
          errors++; $display("FAIL rand%0d_read: data=%h required %h (port id %0d)", n, rd,
            exp_read(last_rword, int'(a[2:0]), int'(sz)), m);
        end
      end
    end
    ar_delay = 0; aw_delay = 0; w_delay = 0; rd_resp = 0; wr_resp = 0;
  endtask

  task automatic test_reset_mid();
    logic [63:0] rd; logic [1:0] rs; int lat, n, mp;
    r_hold = 1; mp = mem_pulses;
    mem_valid = 1; mem_req = 0; mem_addr = 64'h40; mem_size = 2'd3;
    n = 0;
    do begin tick(); n++; end while (!axi_r_ready && n < 50);
    checks++;
    if (!axi_r_ready) begin errors++; $display("FAIL midrst_reach: r_ready=%b required 1", axi_r_ready); end
    reset = 1; mem_valid = 0;
    tick();
    checks++;
    if ({axi_ar_valid, axi_r_ready, mem_ready, if_ready} !== 4'b0 || mem_pulses !== mp) begin
      errors++; $display("FAIL midrst_idle: ar_v/r_rdy/mem_rdy/if_rdy=%b pulses=%0d required 0000 0",
        {axi_ar_valid, axi_r_ready, mem_ready, if_ready}, mem_pulses - mp);
    end
`ifdef CPU_AXI_BRIDGE_PERF_EN
    checks++;
    if ({perf_rd_cnt, perf_wr_cnt, perf_stall_cnt} !== '0) begin
      errors++; $display("FAIL midrst_perf: %0d %0d %0d required 0", perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
`endif
    reset = 0; r_hold = 0;
    tick();
    run_txn(0, 0, 64'h8, 2'd2, '0, rd, rs, lat);
    checks++;
    if (lat !== 3 || rd !== exp_read(last_rword, 0, 2)) begin
      errors++; $display("FAIL midrst_recover: lat=%0d data=%h required 3 %h", lat, rd, exp_read(last_rword, 0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_byte_store();
    test_write_order();
    test_arbitration();
    test_error();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_axi_bridge.md
Name: cpu_axi_bridge

Overview:
Downstream neighbour of the single-cycle core. Takes the core's instruction-fetch port (if_*) and data-memory port (mem_*) and serialises them onto one AXI4 master interface. Only one transaction is in flight at a time, and every burst is a single beat. The block handles byte-lane alignment in both directions, so the core always sees right-justified read data and supplies right-justified write data.

Parameters:
ADDR_W, 64, address width on both the core and AXI sides
DATA_W, 64, data width on both the core and AXI sides
ID_W, 4, AXI ID width
IF_ID, 0, ARID used for fetches
MEM_ID, 1, ARID/AWID used for data accesses

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
if_valid  in  1  fetch request
if_addr  in  ADDR_W  fetch address
if_size  in  2  access size: 0=B, 1=H, 2=W, 3=D
if_req  in  1  0=read; always 0 for fetches
if_ready  out  1  one-cycle completion pulse for a fetch
if_data_read  out  DATA_W  right-justified fetch data
if_resp  out  2  RRESP of the fetch
mem_valid  in  1  data request
mem_req  in  1  0=read, 1=write
mem_addr  in  ADDR_W  data address
mem_size  in  2  access size, same encoding as if_size
mem_data_write  in  DATA_W  right-justified write data
mem_ready  out  1  one-cycle completion pulse for a data access
mem_data_read  out  DATA_W  right-justified read data
mem_resp  out  2  RRESP or BRESP of the data access
axi_aw_valid/ready/addr/size/id  out/in/out/out/out  1/1/ADDR_W/3/ID_W  AXI write-address channel
axi_w_valid/ready/data/strb/last  out/in/out/out/out  1/1/DATA_W/DATA_W/8/1  AXI write-data channel
axi_b_valid/ready/resp/id  in/out/in/in  1/1/2/ID_W  AXI write-response channel
axi_ar_valid/ready/addr/size/id  out/in/out/out/out  1/1/ADDR_W/3/ID_W  AXI read-address channel
axi_r_valid/ready/data/resp/last/id  in/out/in/in/in/in  1/1/DATA_W/2/1/ID_W  AXI read-data channel
AWLEN/ARLEN are tied to 0 and AWBURST/ARBURST to INCR at the top level; they are not state.

Behaviour:
- Core handshake
  - The requester holds valid and all fields stable until its ready pulse.
  - Ready is high for exactly one cycle, together with data and resp.
- Reset
  - State returns to IDLE.
  - All AXI valids, if_ready and mem_ready go to 0; data outputs and resp go to 0.
  - Reset asserted mid-transaction abandons it; the slave shares the same reset.
- FSM states: IDLE, RD_AR, RD_R, WR_AWW, WR_B, RESP.
- IDLE
  - If mem_valid: latch the mem request with id=MEM_ID, then go to WR_AWW if mem_req=1, else RD_AR.
  - Else if if_valid: latch the fetch with id=IF_ID and go to RD_AR.
  - Mem has fixed priority over fetch when both are valid.
- RD_AR: ar_valid=1. When ar_ready is seen, go to RD_R. ar_valid drops the cycle after the handshake.
- RD_R
  - r_ready=1.
  - On r_valid: data is shifted right by addr[2:0]*8, then zero-masked to the access size and registered.
  - resp is registered and the FSM goes to RESP.
  - r_last is ignored.
- WR_AWW
  - aw_valid and w_valid assert together; each drops independently after its own handshake.
  - Handshakes may complete in either order or in the same cycle.
  - Go to WR_B only when both channels are done.
  - wdata = write data shifted left by addr[2:0]*8; w_last=1.
  - wstrb = ((1<<(1<<size))-1) << addr[2:0], i.e. 0x01/0x03/0x0F/0xFF before the shift.
- WR_B: b_ready=1. On b_valid, register the resp and go to RESP.
- RESP
  - Pulse ready on the latched requester's port only; the other port stays 0.
  - Return to IDLE.
  - A new request can be accepted in the next cycle.
- Timing
  - Minimum read latency: valid to ready = 3 cycles with a zero-wait slave.
  - Minimum write latency: 3 cycles.
- AXI addr/size: axi size = {1'b0, size}; the address is passed through unaligned.
- Misalignment: the bridge does not check it. An access crossing 8 bytes is truncated by the strobe mask, and the core is responsible for avoiding it.
- Response ID: an ID mismatch on R or B is ignored; only one transaction is ever outstanding.

Optional Feature:
- Macro: CPU_AXI_BRIDGE_PERF_EN.
- When defined, adds these output ports:
  - perf_rd_cnt [63:0]: increments on each completed read.
  - perf_wr_cnt [63:0]: increments on each completed write.
  - perf_stall_cnt [63:0]: increments each cycle the state is not IDLE.
- All counters clear on reset and wrap modulo 2^64.
- When undefined, these ports and their counters do not exist and behaviour is otherwise identical.

Decomposition:
- Shared defines file holds:
  - FSM state encodings (3-bit).
  - AXI_SIZE_B/H/W/D.
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR.
  - IF_ID/MEM_ID defaults.
- One sub-module, axi_lane_align, is combinational: it produces wdata, wstrb and aligned rdata from size and addr[2:0].

Test Plan:
1. Fetch: if_valid, addr 0x8000_0004, size 2, slave returns 0x1234_5678_0000_0000 OKAY → if_data_read=0x1234_5678, if_resp=0, if_ready pulses once, 3 cycles after if_valid.
2. Byte store: mem_req=1, addr 0x8000_1003, size 0, data 0xAB → wdata byte 3 = 0xAB, wstrb=0x08, mem_ready one cycle after b_valid.
3. Write channel ordering: w_ready arrives 4 cycles before aw_ready → w_valid drops after its handshake; b_ready asserts only after both handshakes; repeat with aw first and with both in the same cycle.
4. Arbitration: if_valid and mem_valid (read) both rise in the same cycle → AR carries id=1 first; fetch is served afterwards with id=0; if_ready never pulses during the mem transaction.
5. Error response: rresp=2'b10 on a data load → mem_resp=2'b10, mem_ready pulses, FSM returns to IDLE.
6. Reset mid-flight: assert reset while in RD_R → next cycle ar_valid=r_ready=0, state IDLE, no ready pulse; with the macro defined, perf counters read 0.
